// File: rtl/seg7_scan_ctrl.sv
// Eight-digit seven-segment scan controller: dark gap, then lit slot, per digit.
// Optional leading-zero suppression when SEG7_SCAN_LZ_BLANK_EN is defined.
module seg7_scan_ctrl #(
    parameter int SHOW_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    output logic [3:0] num,
    output logic [2:0] sel,
    output logic       dp,
    output logic       digit_en,
    output logic       frame_tick
);
    localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0][3:0]  digit_mem_q, digit_mem_d;
    logic [7:0]       dp_mem_q, dp_mem_d;
    logic             digit_en_q, digit_en_d;
    logic             frame_tick_q, frame_tick_d;
    logic             lz_suppress;

    always_comb begin
        digit_mem_d = digit_mem_q;
        dp_mem_d    = dp_mem_q;
        if (wr_en) begin
            digit_mem_d[wr_addr] = wr_data;
            dp_mem_d[wr_addr]    = wr_dp;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        frame_tick_d = 1'b0;
        if (!en) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
        end else if (state_q == ST_BLANK) begin
            if (cnt_q == BLANK_LAST) begin
                state_d = ST_SHOW;
                cnt_d   = '0;
            end
        end else if (cnt_q == SHOW_LAST) begin
            state_d      = ST_BLANK;
            cnt_d        = '0;
            idx_d        = idx_q + 3'd1;
            frame_tick_d = (idx_q == 3'd7);
        end
    end

`ifdef SEG7_SCAN_LZ_BLANK_EN
    // Evaluated on next-cycle contents so digit_en tracks the registered num/sel.
    logic [7:0] zero_from;
    logic       zero_acc;
    always_comb begin
        zero_from = '0;
        zero_acc  = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            zero_acc     = zero_acc & (digit_mem_d[i] == 4'h0);
            zero_from[i] = zero_acc;
        end
        lz_suppress = (idx_d != 3'd0) && zero_from[idx_d];
    end
`else
    assign lz_suppress = 1'b0;
`endif

    assign digit_en_d = (state_d == ST_SHOW) && !lz_suppress;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            digit_mem_q  <= '0;
            dp_mem_q     <= '0;
            digit_en_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            digit_mem_q  <= digit_mem_d;
            dp_mem_q     <= dp_mem_d;
            digit_en_q   <= digit_en_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign sel        = idx_q;
    assign num        = digit_mem_q[idx_q];
    assign dp         = dp_mem_q[idx_q];
    assign digit_en   = digit_en_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random traffic against a
// slot-position reference model.
module tb_seg7_scan_ctrl;
    localparam int SHOW  = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = SHOW + BLANK;

    logic       clk = 1'b0;
    logic       rst, en, wr_en, wr_dp;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] num;
    logic [2:0] sel;
    logic       dp, digit_en, frame_tick;

    seg7_scan_ctrl #(.SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .num(num), .sel(sel), .dp(dp),
        .digit_en(digit_en), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: each digit occupies a SLOT-cycle window; m_pos is the offset into it.
    int m_mem [8];
    int m_dp  [8];
    int m_idx, m_pos, m_tick;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit lz_blank();
        bit all_zero = 1'b1;
`ifdef SEG7_SCAN_LZ_BLANK_EN
        for (int j = m_idx; j < 8; j++) if (m_mem[j] != 0) all_zero = 1'b0;
        return (m_idx != 0) && all_zero;
`else
        all_zero = 1'b0;
        return all_zero;
`endif
    endfunction

    task automatic cycle(input bit r, input bit e, input bit we, input int a, input int d, input int p);
        rst = r; en = e; wr_en = we;
        wr_addr = a[2:0]; wr_data = d[3:0]; wr_dp = p[0];
        @(posedge clk);
        cyc++;
        if (r) begin
            for (int j = 0; j < 8; j++) begin m_mem[j] = 0; m_dp[j] = 0; end
            m_idx = 0; m_pos = 0; m_tick = 0;
        end else begin
            if (we) begin m_mem[a & 7] = d & 15; m_dp[a & 7] = p & 1; end
            m_tick = 0;
            if (!e) m_pos = 0;
            else if (m_pos == SLOT - 1) begin
                m_pos  = 0;
                m_tick = (m_idx == 7);
                m_idx  = (m_idx + 1) % 8;
            end else m_pos++;
        end
        @(negedge clk);
        chk("sel", int'(sel), m_idx);
        chk("num", int'(num), m_mem[m_idx]);
        chk("dp", int'(dp), m_dp[m_idx]);
        chk("digit_en", int'(digit_en), int'((m_pos >= BLANK) && !lz_blank()));
        chk("frame_tick", int'(frame_tick), m_tick);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 0);
    endtask

    task automatic run_until(input int idx, input int pos);
        int n = 0;
        while (!(m_idx == idx && m_pos == pos) && n < 200) begin
            cycle(0, 1, 0, 0, 0, 0);
            n++;
        end
        chk("run_until_timeout", int'(n < 200), 1);
    endtask

    initial begin
        int ticks[$];
        rst = 1; en = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_dp = 0;
        @(negedge clk);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);

        // release reset with scanning on: 2 dark, 4 lit, next digit
        idle(20);

        for (int i = 0; i < 8; i++) cycle(0, 1, 1, i, i + 1, int'(i == 3));
        for (int i = 0; i < 110; i++) begin
            cycle(0, 1, 0, 0, 0, 0);
            if (frame_tick) ticks.push_back(cyc);
        end
        chk("tick_count_ge2", int'(ticks.size() >= 2), 1);
        if (ticks.size() >= 2) chk("tick_gap", ticks[1] - ticks[0], 8 * SLOT);

        run_until(2, BLANK + 1);
        cycle(0, 1, 1, 2, 10, 0);
        chk("num_after_midshow_wr", int'(num), 10);
        idle(3);

        run_until(5, BLANK + 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);
        chk("sel_held_en_low", int'(sel), 5);
        idle(SLOT);

        // write to another address on the idx-advance edge
        run_until(6, SLOT - 1);
        cycle(0, 1, 1, 7, 12, 1);
        idle(2);

        run_until(6, BLANK + 1);
        cycle(1, 1, 1, 3, 9, 1);
        chk("rst_sel", int'(sel), 0);
        chk("rst_num", int'(num), 0);
        idle(8 * SLOT);

        // leading-zero pattern d0=5 d1=0 d2=3
        cycle(0, 1, 1, 0, 5, 0);
        cycle(0, 1, 1, 2, 3, 0);
        idle(8 * SLOT + 4);
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 1, 1, 2, 0, 0);
        idle(8 * SLOT + 4);

        for (int i = 0; i < 3000; i++) begin
            bit r  = ($urandom_range(0, 199) == 0);
            bit e  = ($urandom_range(0, 15) != 0);
            bit we = ($urandom_range(0, 3) == 0);
            int d  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 15));
            cycle(r, e, we, int'($urandom_range(0, 7)), d, int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
